// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the gshare pattern history table controller
//
// Contents:
//   cnt_e      - 2-bit saturating counter encoding (SNT/WNT/WT/ST); prediction is bit 1
//   CNT_RESET  - value written on reset and by the clear sequence (weakly not-taken)
//   state_e    - clear sequencer states (IDLE, CLEAR)
//   sat_update - pure counter update: taken counts up, not-taken counts down, both saturate
package bp_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_RESET = CNT_WNT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic cnt_e sat_update(input cnt_e cnt, input logic taken);
        cnt_e nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                nxt = cnt_e'(cnt + 2'd1);
            end
        end else begin
            if (cnt != CNT_SNT) begin
                nxt = cnt_e'(cnt - 2'd1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht_ctrl.sv
// rtl/gshare_pht_ctrl.sv - gshare predictor controller: PHT of 2-bit counters, global history, clear sequencer
//
// Ports:
//   clock, reset                    - rising-edge clock, asynchronous active-high reset
//   lookup_valid, lookup_pc         - fetch-side branch lookup (one per cycle)
//   lookup_pred                     - predicted direction, combinational from current state
//   lookup_idx                      - PHT index used, travels with the branch to resolve
//   lookup_ghr                      - history before this lookup's speculative shift (checkpoint)
//   resolve_valid, resolve_idx      - execute-side resolution of a previously looked-up branch
//   resolve_ghr                     - checkpoint returned from lookup_ghr
//   resolve_taken, resolve_mispred  - actual direction and mispredict flag
//   clear_req                       - start a full PHT/history clear
//   busy                            - clear sequence in progress (registered)
module gshare_pht_ctrl
    import bp_pkg::*;
#(
    parameter int PHT_ENTRIES = 64,
    parameter int GHR_BITS    = 6,
    localparam int IDX_W      = $clog2(PHT_ENTRIES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lookup_valid,
    input  logic [31:0]         lookup_pc,
    output logic                lookup_pred,
    output logic [IDX_W-1:0]    lookup_idx,
    output logic [GHR_BITS-1:0] lookup_ghr,
    input  logic                resolve_valid,
    input  logic [IDX_W-1:0]    resolve_idx,
    input  logic [GHR_BITS-1:0] resolve_ghr,
    input  logic                resolve_taken,
    input  logic                resolve_mispred,
    input  logic                clear_req,
    output logic                busy
);

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(PHT_ENTRIES - 1);

    logic [PHT_ENTRIES-1:0][1:0] pht;
    logic [GHR_BITS-1:0]         ghr;
    logic [IDX_W-1:0]            clear_ptr;
    state_e                      state;

    // History may be shorter than the index; it is zero-extended so it only
    // perturbs the low index bits.
    function automatic logic [IDX_W-1:0] pht_hash(input logic [IDX_W-1:0]    pc_bits,
                                                  input logic [GHR_BITS-1:0] hist);
        logic [IDX_W-1:0] hist_ext;
        hist_ext                 = '0;
        hist_ext[GHR_BITS-1:0]   = hist;
        return pc_bits ^ hist_ext;
    endfunction

    // Instruction-aligned PC: bits [1:0] carry no information, and bits above
    // the index are not part of the hash.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], resolve_ghr[GHR_BITS-1]};

    // ------------------------------------------------------------------
    // Combinational lookup. There is deliberately no bypass from a
    // resolve in the same cycle: the lookup sees the stored counter.
    // ------------------------------------------------------------------
    assign lookup_idx  = pht_hash(lookup_pc[IDX_W+1:2], ghr);
    assign lookup_ghr  = ghr;
    assign lookup_pred = busy ? 1'b0 : pht[lookup_idx][1];

    // ------------------------------------------------------------------
    // Counter array. While clearing, the sequencer owns the write port
    // and resolves are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_RESET;
            end
        end else if (state == ST_CLEAR) begin
            pht[clear_ptr] <= CNT_RESET;
        end else if (resolve_valid) begin
            pht[resolve_idx] <= sat_update(cnt_e'(pht[resolve_idx]), resolve_taken);
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer and global history.
    // History priority in IDLE: clear > mispredict restore > speculative shift.
    // A restore rebuilds history from the branch's checkpoint plus its real
    // outcome, discarding any younger speculative shifts.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            clear_ptr <= '0;
            ghr       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        busy      <= 1'b1;
                        clear_ptr <= '0;
                        ghr       <= '0;
                    end else if (resolve_valid && resolve_mispred) begin
                        ghr <= {resolve_ghr[GHR_BITS-2:0], resolve_taken};
                    end else if (lookup_valid) begin
                        ghr <= {ghr[GHR_BITS-2:0], lookup_pred};
                    end
                end
                ST_CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == LAST_PTR) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
